// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits that
// share one external hex-to-seven-segment decoder. The displayed value is held
// in a shadow register that only changes at frame boundaries, so every frame
// shows one coherent value. Each digit slot opens with a blanking window to
// suppress ghosting.
// Optional build macro: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN (suppresses
// leading zero digits above digit 0).
module seven_segment_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                      Clk,
    input  logic                      RstN,
    input  logic [4*NUM_DIGITS-1:0]   ValueIn,
    input  logic                      LoadIn,
    output logic                      BusyOut,
    output logic                      UpdatedOut,
    output logic [3:0]                DigitCodeOut,
    input  logic [6:0]                SegIn,
    output logic [6:0]                SegOut,
    output logic [NUM_DIGITS-1:0]     AnodeOut
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = '1;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    // With blanking disabled every slot starts directly in SHOW.
    localparam state_t RESET_STATE = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    // Scan timing state
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    state_t                  r_state;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    state_t                  w_state_nxt;
    logic                    w_slot_end;
    logic                    w_boundary;

    // Display value storage
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_hold;
    logic                    r_pending;
    logic                    r_updated;

    // Registered drive and its next values
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_anode_nxt;
    logic [NUM_DIGITS-1:0]   w_anode_sel;
    logic [3:0]              w_code;
    logic                    w_digit_off;

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_boundary = w_slot_end && (r_idx == IDX_LAST);

    // Select the shadow nibble and the anode pattern for the current digit.
    always_comb begin
        w_code      = '0;
        w_anode_sel = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_code         = r_shadow[4*i +: 4];
                w_anode_sel[i] = 1'b0;
            end
        end
    end

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    // Flag the current digit when it and every more-significant nibble are zero.
    always_comb begin : lz_blank
        logic v_zero_run;
        v_zero_run  = 1'b1;
        w_digit_off = 1'b0;
        for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
            v_zero_run = v_zero_run && (r_shadow[4*(i-1) +: 4] == 4'h0);
            if ((i > 1) && (r_idx == IDX_W'(i - 1)) && v_zero_run) begin
                w_digit_off = 1'b1;
            end
        end
    end
`else
    assign w_digit_off = 1'b0;
`endif

    // State register: slot counter, digit index and BLANK/SHOW phase.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= RESET_STATE;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic; the phase follows the next counter
    // value so that the registered state always matches the counter.
    always_comb begin
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_seg_nxt   = SEG_OFF;
        w_anode_nxt = '1;
        if (w_slot_end) begin
            w_cnt_nxt = '0;
            w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
        w_state_nxt = (32'(w_cnt_nxt) < BLANK_CYCLES) ? ST_BLANK : ST_SHOW;
        if ((r_state == ST_SHOW) && !w_digit_off) begin
            w_seg_nxt   = SegIn;
            w_anode_nxt = w_anode_sel;
        end
    end

    // Load handling: buffer loads until the frame boundary; a load on the
    // boundary itself goes straight to the shadow and drops any older hold.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_shadow  <= '0;
            r_hold    <= '0;
            r_pending <= 1'b0;
            r_updated <= 1'b0;
        end else begin
            r_updated <= 1'b0;
            if (w_boundary) begin
                if (LoadIn) begin
                    r_shadow  <= ValueIn;
                    r_pending <= 1'b0;
                    r_updated <= 1'b1;
                end else if (r_pending) begin
                    r_shadow  <= r_hold;
                    r_pending <= 1'b0;
                    r_updated <= 1'b1;
                end
            end else if (LoadIn) begin
                r_hold    <= ValueIn;
                r_pending <= 1'b1;
            end
        end
    end

    // Segment and anode drive, registered together so they never misalign.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_seg   <= SEG_OFF;
            r_anode <= '1;
        end else begin
            r_seg   <= w_seg_nxt;
            r_anode <= w_anode_nxt;
        end
    end

    assign DigitCodeOut = w_code;
    assign SegOut       = r_seg;
    assign AnodeOut     = r_anode;
    assign BusyOut      = r_pending;
    assign UpdatedOut   = r_updated;

endmodule
